// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: FSM state encoding and next-PC select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    S_NORMAL   = 2'd0,
    S_JUMP     = 2'd1,
    S_BR_WAIT  = 2'd2,
    S_BR_TAKEN = 2'd3
  } hazard_state_t;

  localparam logic [1:0] ADDR_PC4    = 2'b00;
  localparam logic [1:0] ADDR_JUMP   = 2'b01;
  localparam logic [1:0] ADDR_BRANCH = 2'b10;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use dependence check between the load in EX and the source operands in ID.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             MemReadEX,
  input  logic [REG_W-1:0] RtEX,
  input  logic [REG_W-1:0] RsID,
  input  logic [REG_W-1:0] RtID,
  input  logic             UseShamt,
  input  logic             UseImmed,
  output logic             LU
);

  logic rsHitS;
  logic rtHitS;
  logic loadLiveS;

  // A load into $zero never produces a value, so it cannot create a dependence.
  always_comb begin
    loadLiveS = MemReadEX && (RtEX != {REG_W{1'b0}});
    rsHitS    = (RtEX == RsID) && !UseShamt;
    rtHitS    = (RtEX == RtID) && !UseImmed;
    LU        = loadLiveS && (rsHitS || rtHitS);
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard FSM: load-use stall, post-jump bubble, and branch hold until ALUZero resolves in EX.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             ALUZero,
  input  logic             MemReadEX,
  input  logic [REG_W-1:0] RtEX,
  input  logic [REG_W-1:0] RsID,
  input  logic [REG_W-1:0] RtID,
  input  logic             UseShamt,
  input  logic             UseImmed,
  output logic             PCWrite,
  output logic             IFWrite,
  output logic             Bubble,
  output logic [1:0]       AddrSel
);

  hazard_state_t stateR;
  hazard_state_t nextStateS;
  logic          luS;

  load_use_detect #(.REG_W(REG_W)) uLoadUse (
    .MemReadEX (MemReadEX),
    .RtEX      (RtEX),
    .RsID      (RsID),
    .RtID      (RtID),
    .UseShamt  (UseShamt),
    .UseImmed  (UseImmed),
    .LU        (luS)
  );

  // State register.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      stateR <= S_NORMAL;
    end else begin
      stateR <= nextStateS;
    end
  end

  // Output decode and next state; reset overrides everything so fetch is frozen while held.
  always_comb begin
    nextStateS = S_NORMAL;
    Bubble     = 1'b1;
    PCWrite    = 1'b0;
    IFWrite    = 1'b0;
    AddrSel    = ADDR_PC4;
    if (!Reset_L) begin
      nextStateS = S_NORMAL;
    end else begin
      case (stateR)
        S_NORMAL: begin
          if (luS) begin
            nextStateS = S_NORMAL;
          end else if (Jump) begin
            Bubble     = 1'b0;
            PCWrite    = 1'b1;
            AddrSel    = ADDR_JUMP;
            nextStateS = S_JUMP;
          end else if (Branch) begin
            Bubble     = 1'b0;
            nextStateS = S_BR_WAIT;
          end else begin
            Bubble     = 1'b0;
            PCWrite    = 1'b1;
            IFWrite    = 1'b1;
            nextStateS = S_NORMAL;
          end
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          IFWrite    = 1'b1;
          nextStateS = S_NORMAL;
        end
        S_BR_WAIT: begin
          PCWrite = 1'b1;
          if (ALUZero) begin
            AddrSel    = ADDR_BRANCH;
            nextStateS = S_BR_TAKEN;
          end else begin
            IFWrite    = 1'b1;
            nextStateS = S_NORMAL;
          end
        end
        S_BR_TAKEN: begin
          PCWrite    = 1'b1;
          IFWrite    = 1'b1;
          nextStateS = S_NORMAL;
        end
        default: begin
          PCWrite    = 1'b1;
          IFWrite    = 1'b1;
          nextStateS = S_NORMAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench: directed vector table from reset, mid-cycle reset, then random stimulus vs a slot model.
module tb_pipeline_hazard_unit;

  logic       CLK = 1'b0;
  logic       Reset_L;
  logic       Jump, Branch, ALUZero, MemReadEX, UseShamt, UseImmed;
  logic [4:0] RtEX, RsID, RtID;
  logic       PCWrite, IFWrite, Bubble;
  logic [1:0] AddrSel;

  int nCompared = 0;
  int nMismatched = 0;

  pipeline_hazard_unit #(.REG_W(5)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .Jump(Jump), .Branch(Branch), .ALUZero(ALUZero),
    .MemReadEX(MemReadEX), .RtEX(RtEX), .RsID(RsID), .RtID(RtID),
    .UseShamt(UseShamt), .UseImmed(UseImmed),
    .PCWrite(PCWrite), .IFWrite(IFWrite), .Bubble(Bubble), .AddrSel(AddrSel)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       rst;
    logic       j, b, z, mr;
    logic [4:0] rtEx, rs, rt;
    logic       us, ui;
    logic [4:0] exp;   // {Bubble, PCWrite, IFWrite, AddrSel}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst, logic j, logic b, logic z, logic mr,
                              logic [4:0] rtEx, logic [4:0] rs, logic [4:0] rt,
                              logic us, logic ui, logic [4:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.j = j; v.b = b; v.z = z; v.mr = mr;
    v.rtEx = rtEx; v.rs = rs; v.rt = rt; v.us = us; v.ui = ui; v.exp = exp;
    return v;
  endfunction

  task automatic drive(logic rst, logic j, logic b, logic z, logic mr,
                       logic [4:0] rtEx, logic [4:0] rs, logic [4:0] rt, logic us, logic ui);
    Reset_L = rst; Jump = j; Branch = b; ALUZero = z; MemReadEX = mr;
    RtEX = rtEx; RsID = rs; RtID = rt; UseShamt = us; UseImmed = ui;
  endtask

  task automatic check(string name, logic [4:0] exp);
    logic [4:0] act;
    act = {Bubble, PCWrite, IFWrite, AddrSel};
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got B/PW/IW/AS=%b/%b/%b/%b expected %b/%b/%b/%b", name,
               act[4], act[3], act[2], act[1:0], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // Reference model: pending fetch-slot obligation. 0 none, 1 one squash bubble owed,
  // 2 branch held awaiting its ALUZero outcome.
  int pend = 0;

  function automatic logic [5:0] model(logic rst, logic j, logic b, logic z, logic mr,
                                       logic [4:0] rtEx, logic [4:0] rs, logic [4:0] rt,
                                       logic us, logic ui, int p, output int np);
    bit lu;
    np = 0;
    if (!rst) return {1'b0, 5'b10000};
    if (p == 1) begin np = 0; return {1'b0, 5'b11100}; end
    if (p == 2) begin
      np = z ? 1 : 0;
      return z ? {1'b0, 5'b11010} : {1'b0, 5'b11100};
    end
    lu = mr && (rtEx != 0) && ((rtEx == rs && !us) || (rtEx == rt && !ui));
    if (lu) return {1'b0, 5'b10000};
    if (j) begin np = 1; return {1'b0, 5'b01001}; end
    if (b) begin np = 2; return {1'b0, 5'b00000}; end
    return {1'b0, 5'b01100};
  endfunction

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    //               name          rst  j     b     z     mr    rtEx   rs     rt     us    ui    exp
    vecs.push_back(mk("reset",      1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,5'b10000));
    vecs.push_back(mk("idle",       1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b01100));
    vecs.push_back(mk("lu_rs",      1'b1,1'b0,1'b0,1'b0,1'b1,5'd8, 5'd8, 5'd2, 1'b0,1'b0,5'b10000));
    vecs.push_back(mk("lu_clear",   1'b1,1'b0,1'b0,1'b0,1'b0,5'd8, 5'd8, 5'd2, 1'b0,1'b0,5'b01100));
    vecs.push_back(mk("lu_r0",      1'b1,1'b0,1'b0,1'b0,1'b1,5'd0, 5'd0, 5'd0, 1'b0,1'b0,5'b01100));
    vecs.push_back(mk("lu_immed",   1'b1,1'b0,1'b0,1'b0,1'b1,5'd8, 5'd3, 5'd8, 1'b0,1'b1,5'b01100));
    vecs.push_back(mk("lu_shamt",   1'b1,1'b0,1'b0,1'b0,1'b1,5'd8, 5'd8, 5'd3, 1'b1,1'b0,5'b01100));
    vecs.push_back(mk("lu_rt",      1'b1,1'b0,1'b0,1'b0,1'b1,5'd8, 5'd3, 5'd8, 1'b0,1'b0,5'b10000));
    vecs.push_back(mk("jump_c0",    1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b01001));
    vecs.push_back(mk("jump_c1",    1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b11100));
    vecs.push_back(mk("jump_c2",    1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b01100));
    vecs.push_back(mk("bnt_c0",     1'b1,1'b0,1'b1,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b00000));
    vecs.push_back(mk("bnt_c1",     1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b11100));
    vecs.push_back(mk("bnt_c2",     1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b01100));
    vecs.push_back(mk("bt_c0",      1'b1,1'b0,1'b1,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b00000));
    vecs.push_back(mk("bt_c1",      1'b1,1'b0,1'b0,1'b1,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b11010));
    vecs.push_back(mk("bt_c2",      1'b1,1'b0,1'b0,1'b1,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b11100));
    vecs.push_back(mk("bt_c3",      1'b1,1'b0,1'b0,1'b1,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b01100));
    vecs.push_back(mk("prio_lu0",   1'b1,1'b1,1'b1,1'b0,1'b1,5'd8, 5'd8, 5'd2, 1'b0,1'b0,5'b10000));
    vecs.push_back(mk("prio_lu1",   1'b1,1'b1,1'b1,1'b0,1'b1,5'd8, 5'd8, 5'd2, 1'b0,1'b0,5'b10000));
    vecs.push_back(mk("prio_jump",  1'b1,1'b1,1'b1,1'b0,1'b0,5'd8, 5'd8, 5'd2, 1'b0,1'b0,5'b01001));
    vecs.push_back(mk("prio_jbub",  1'b1,1'b0,1'b1,1'b1,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b11100));
    vecs.push_back(mk("prio_norm",  1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b01100));
    vecs.push_back(mk("rst_br_c0",  1'b1,1'b0,1'b1,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b00000));
    vecs.push_back(mk("rst_in_brw", 1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b10000));
    vecs.push_back(mk("rst_after",  1'b1,1'b0,1'b0,1'b1,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,5'b01100));

    @(negedge CLK);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].j, vecs[i].b, vecs[i].z, vecs[i].mr,
            vecs[i].rtEx, vecs[i].rs, vecs[i].rt, vecs[i].us, vecs[i].ui);
      #1;
      check(vecs[i].name, vecs[i].exp);
      @(negedge CLK);
    end

    // Reset pulled low mid-cycle while a branch waits: outputs must change without a clock edge.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    @(negedge CLK);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    #1;
    check("brw_before_rst", 5'b11010);
    Reset_L = 1'b0;
    #1;
    check("async_rst", 5'b10000);
    @(negedge CLK);
    Reset_L = 1'b1;
    #1;
    check("async_rst_release", 5'b01100);
    @(negedge CLK);

    // Random stimulus against the slot model.
    pend = 0;
    for (int c = 0; c < 600; c++) begin
      logic rst, j, b, z, mr, us, ui;
      logic [4:0] rtEx, rs, rt;
      logic [5:0] e;
      int np;
      rst  = ($urandom_range(0, 49) != 0);
      j    = ($urandom_range(0, 5) == 0);
      b    = ($urandom_range(0, 5) == 0);
      z    = 1'($urandom_range(0, 1));
      mr   = 1'($urandom_range(0, 1));
      rtEx = 5'($urandom_range(0, 3));
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      us   = ($urandom_range(0, 3) == 0);
      ui   = ($urandom_range(0, 3) == 0);
      drive(rst, j, b, z, mr, rtEx, rs, rt, us, ui);
      e = model(rst, j, b, z, mr, rtEx, rs, rt, us, ui, pend, np);
      #1;
      check($sformatf("rand_%0d", c), e[4:0]);
      @(posedge CLK);
      pend = np;
      @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
